dzcpu_useq: RTL
===============

# dzcpu_useq

Parametrised microcode sequencer for the dzcpu core, replacing the fixed dispatch-LUT/ROM pair. It holds a run-time-loadable micro-op store and two opcode dispatch tables, main and 0xCB-prefixed. It accepts one macro-opcode at a time and steps a micro-PC through the micro-op flow, issuing one micro-op per cycle to the datapath. Sequencing is driven by a control field in each micro-op: continue, PC-increment, end-of-flow, Z-conditional end, CB prefix.

## Interface
- UOP_W, 13, micro-op width; top 3 bits are the sequencing field SEQ = uop[UOP_W-1 -: 3].
- ADDR_W, 8, micro-PC / micro-store address width.
- DEPTH, 256, micro-store entries (≤ 2^ADDR_W).
- iClock  in  1  clock.
- iReset  in  1  asynchronous, active-high reset.
- iOpValid  in  1  macro-opcode offered.
- iOpcode  in  8  macro-opcode byte.
- oOpReady  out  1  sequencer can accept an opcode.
- iFlagZ  in  1  current Z flag, used by the conditional-end codes.
- iWait  in  1  datapath stall; present only with DZCPU_USEQ_WAIT_EN.
- oUop  out  UOP_W  current micro-op; 0 when oUopValid=0.
- oUopValid  out  1  oUop is live this cycle.
- oPcInc  out  1  pulse: datapath increments PC this cycle.
- oEof  out  1  pulse: last micro-op of the flow.
- oUpc  out  ADDR_W  current micro-PC.
- iLoadEn  in  1  table write strobe.
- iLoadSel  in  2  0 = micro-store, 1 = main dispatch, 2 = CB dispatch, 3 = ignored.
- iLoadAddr  in  ADDR_W  write index; dispatch tables use bits [7:0].
- iLoadData  in  UOP_W  write data; dispatch tables use bits [ADDR_W-1:0].

## Operation
- States: FETCH, EXEC, CBWAIT. oOpReady=1 in FETCH and CBWAIT. oUopValid=1 only in EXEC.
- FETCH: on iOpValid & oOpReady, uPC ← main[iOpcode] and the state goes to EXEC.
- CBWAIT: on accept, uPC ← cb[iOpcode] and the state goes to EXEC.
- EXEC: oUop = ustore[uPC]. The action depends on SEQ:
  - 0 op: uPC+1.
  - 1 inc: oPcInc=1; uPC+1.
  - 2 eof: oEof=1; go to FETCH.
  - 3 inc_eof: oPcInc=1, oEof=1; go to FETCH.
  - 4 inc_eof_z: oPcInc=1. If iFlagZ=1: oEof=1 and go to FETCH. Otherwise uPC+1.
  - 5 inc_eof_nz: as code 4 with the Z test inverted.
  - 6 jcb: oPcInc=1; go to CBWAIT.
  - 7 reserved: treated as eof.
- Default dispatch entry is 0, which holds the generic single-byte flow.
- uPC arithmetic is modulo 2^ADDR_W; an increment past all-ones wraps to 0. Addresses ≥ DEPTH read as 0 (an op/nop).
- Loads are accepted only in FETCH with no simultaneous opcode accept. In every other case they are ignored. A written entry is visible from the next cycle.
- If iOpValid and iLoadEn are both high in FETCH, the opcode accept wins and the load is dropped.
- Reset, including mid-flow: state=FETCH, uPC=0, both dispatch tables cleared to 0, oUopValid=oPcInc=oEof=0, oUop=0, oOpReady=1. The micro-store is not reset.

## Timing
- Accept at edge t → first micro-op on oUop in cycle t+1. Latency is 1 cycle; there is no bubble inside a flow.
- oUop, oPcInc and oEof are combinational from the registered uPC/state and are valid for the whole cycle.
- After an eof cycle, oOpReady=1 in the next cycle. Back-to-back flows therefore have 1 idle cycle between them.
- jcb cycle → CBWAIT in the next cycle; a CB opcode accepted there gives its first micro-op one cycle later.
- The Z test samples iFlagZ in the same cycle as the conditional micro-op.

## Configuration
- DZCPU_USEQ_WAIT_EN defined:
  - The iWait port exists.
  - iWait=1 in EXEC freezes uPC and state and forces oPcInc=oEof=0.
  - oUop stays valid and unchanged during the stall.
  - iWait is ignored in FETCH and CBWAIT.
- DZCPU_USEQ_WAIT_EN undefined: no iWait port; the sequencer advances every EXEC cycle.

## Test plan
- Reset, then load main[0x31]=1 and ustore[1..4] SEQ = inc, inc, op, inc_eof. Offer 0x31 → oUpc 1,2,3,4 in consecutive cycles; oPcInc=1,1,0,1; oEof only at uPC 4; oOpReady=1 the next cycle.
- Load main[0xCB]=13 with ustore[13]=jcb, and cb[0x7C]=16 with ustore[16]=eof. Offer 0xCB then 0x7C → oUpc 13, then state CBWAIT, then oUpc 16 with oEof=1.
- Conditional end: JRNZ-style flow with ustore[19]=inc_eof_z.
  - iFlagZ=1 → oEof at 19.
  - iFlagZ=0 → flow continues through uPC 20–22.
- Wrap: main[0x00]=255 with ustore[255]=op (DEPTH=256) → the next oUpc is 0.
- Assert iReset while oUpc=3 → oUopValid=0, oUop=0, and oOpReady=1 immediately. After release, an un-reloaded opcode dispatches to uPC 0.
- With DZCPU_USEQ_WAIT_EN: iWait=1 for 3 cycles at uPC 2 → oUpc stays 2, oPcInc=0, then resumes at 3. A load attempted during EXEC leaves the tables unchanged.

Source files
------------

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer with loadable micro-store and dispatch tables.
// Optional stall input enabled by defining DZCPU_USEQ_WAIT_EN.
module dzcpu_useq #(
    parameter int UOP_W  = 13,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iOpValid,
    input  logic [7:0]        iOpcode,
    output logic              oOpReady,
    input  logic              iFlagZ,
`ifdef DZCPU_USEQ_WAIT_EN
    input  logic              iWait,
`endif
    output logic [UOP_W-1:0]  oUop,
    output logic              oUopValid,
    output logic              oPcInc,
    output logic              oEof,
    output logic [ADDR_W-1:0] oUpc,
    input  logic              iLoadEn,
    input  logic [1:0]        iLoadSel,
    input  logic [ADDR_W-1:0] iLoadAddr,
    input  logic [UOP_W-1:0]  iLoadData
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_CBWAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_upc;
    logic [ADDR_W-1:0] w_upc_nxt;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [ADDR_W-1:0] r_main [256];
    logic [ADDR_W-1:0] r_cb   [256];
    logic [UOP_W-1:0]  r_ustore [DEPTH];
    logic [UOP_W-1:0]  w_uop;
    logic [2:0]        w_seq;
    logic              w_rd_ok;
    logic              w_ld_ok;
    logic              w_accept;
    logic              w_load;
    logic              w_stall;

`ifdef DZCPU_USEQ_WAIT_EN
    assign w_stall = iWait;
`else
    assign w_stall = 1'b0;
`endif

    // Addresses beyond the populated store read back as a plain op.
    generate
        if (DEPTH < (2 ** ADDR_W)) begin : g_range
            assign w_rd_ok = (32'(r_upc) < 32'(DEPTH));
            assign w_ld_ok = (32'(iLoadAddr) < 32'(DEPTH));
        end else begin : g_full
            assign w_rd_ok = 1'b1;
            assign w_ld_ok = 1'b1;
        end
    endgenerate

    assign w_uop     = w_rd_ok ? r_ustore[r_upc[IDX_W-1:0]] : '0;
    assign w_seq     = w_uop[UOP_W-1 -: 3];
    assign w_upc_inc = r_upc + 1'b1;
    assign oOpReady  = (r_state == S_FETCH) || (r_state == S_CBWAIT);
    assign w_accept  = iOpValid && oOpReady;
    assign w_load    = iLoadEn && (r_state == S_FETCH) && !w_accept && !iReset;
    assign oUpc      = r_upc;

    // Next-state, next-uPC and per-cycle micro-op outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        oUop        = '0;
        oUopValid   = 1'b0;
        oPcInc      = 1'b0;
        oEof        = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_upc_nxt   = r_main[iOpcode];
                    w_state_nxt = S_EXEC;
                end
            end
            S_CBWAIT: begin
                if (w_accept) begin
                    w_upc_nxt   = r_cb[iOpcode];
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                oUop      = w_uop;
                oUopValid = 1'b1;
                if (!w_stall) begin
                    unique case (w_seq)
                        3'd0: w_upc_nxt = w_upc_inc;
                        3'd1: begin
                            oPcInc    = 1'b1;
                            w_upc_nxt = w_upc_inc;
                        end
                        3'd3: begin
                            oPcInc      = 1'b1;
                            oEof        = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                        3'd4, 3'd5: begin
                            oPcInc = 1'b1;
                            if (iFlagZ == (w_seq == 3'd4)) begin
                                oEof        = 1'b1;
                                w_state_nxt = S_FETCH;
                            end else begin
                                w_upc_nxt = w_upc_inc;
                            end
                        end
                        3'd6: begin
                            oPcInc      = 1'b1;
                            w_state_nxt = S_CBWAIT;
                        end
                        default: begin
                            oEof        = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    endcase
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Sequencer state, micro-PC and dispatch tables; tables clear on reset.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= S_FETCH;
            r_upc   <= '0;
            for (int i = 0; i < 256; i++) begin
                r_main[i] <= '0;
                r_cb[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            if (w_load && (iLoadSel == 2'd1))
                r_main[iLoadAddr[7:0]] <= iLoadData[ADDR_W-1:0];
            if (w_load && (iLoadSel == 2'd2))
                r_cb[iLoadAddr[7:0]] <= iLoadData[ADDR_W-1:0];
        end
    end

    // Micro-store write port; contents survive reset.
    always_ff @(posedge iClock) begin
        if (w_load && (iLoadSel == 2'd0) && w_ld_ok)
            r_ustore[iLoadAddr[IDX_W-1:0]] <= iLoadData;
    end

endmodule
